// File: rtl/conv_viterbi_decoder.sv
// Hard-decision Viterbi decoder for a rate-1/2, K=3 convolutional code.
// Register-exchange survivors with sliding-window output and a zero-tail flush.
module conv_viterbi_decoder #(
    parameter logic [2:0] G1       = 3'b111,
    parameter logic [2:0] G2       = 3'b101,
    parameter int         TB_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [1:0] in_sym,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_bit,
    output logic       out_last,
    output logic [5:0] frame_metric
);

    localparam int            CW        = $clog2(TB_DEPTH + 1);
    localparam int            FW        = $clog2(TB_DEPTH);
    localparam logic [CW-1:0] CNT_FULL  = CW'(TB_DEPTH);
    localparam logic [CW-1:0] FLUSH_MAX = CW'(TB_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t              state;
    logic [5:0]          pm     [4];
    logic [TB_DEPTH-1:0] sr     [4];
    logic [CW-1:0]       cnt;
    logic [FW-1:0]       flush_idx;

    logic [5:0]          pm_sel [4];
    logic [5:0]          pm_nxt [4];
    logic [TB_DEPTH-1:0] sr_nxt [4];
    logic [1:0]          best;
    logic [CW-1:0]       cnt_nxt;
    logic [CW-1:0]       flush_len;
    logic                accept;
    logic                all_hi;

    function automatic logic [1:0] branch_metric(input logic [2:0] taps, input logic [1:0] sym);
        logic [1:0] diff;
        diff = sym ^ {^(G1 & taps), ^(G2 & taps)};
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

    function automatic logic [5:0] sat_add(input logic [5:0] pm_val, input logic [1:0] bm);
        logic [6:0] sum;
        sum = {1'b0, pm_val} + {5'd0, bm};
        return (sum > 7'd63) ? 6'd63 : sum[5:0];
    endfunction

    assign in_ready  = (state != FLUSH);
    assign accept    = in_valid && in_ready;
    assign cnt_nxt   = (cnt == CNT_FULL) ? cnt : cnt + 1'b1;
    assign flush_len = (cnt_nxt < FLUSH_MAX) ? cnt_nxt : FLUSH_MAX;

    // Predecessors of ns are {ns[0],0} and {ns[0],1}; a tie keeps the s[0]=0 branch.
    always_comb begin
        logic [1:0] ns_b;
        logic [1:0] p0;
        logic [1:0] p1;
        logic [5:0] c0;
        logic [5:0] c1;
        all_hi = 1'b1;
        for (int ns = 0; ns < 4; ns++) begin
            ns_b = 2'(ns);
            p0   = {ns_b[0], 1'b0};
            p1   = {ns_b[0], 1'b1};
            c0   = sat_add(pm[p0], branch_metric({ns_b[1], p0}, in_sym));
            c1   = sat_add(pm[p1], branch_metric({ns_b[1], p1}, in_sym));
            if (c1 < c0) begin
                pm_sel[ns] = c1;
                sr_nxt[ns] = {sr[p1][TB_DEPTH-2:0], ns_b[1]};
            end else begin
                pm_sel[ns] = c0;
                sr_nxt[ns] = {sr[p0][TB_DEPTH-2:0], ns_b[1]};
            end
            if (pm_sel[ns] < 6'd32) all_hi = 1'b0;
        end
        for (int i = 0; i < 4; i++)
            pm_nxt[i] = all_hi ? pm_sel[i] - 6'd32 : pm_sel[i];
    end

    always_comb begin
        best = 2'd0;
        for (int i = 1; i < 4; i++)
            if (pm_nxt[i] < pm_nxt[best]) best = 2'(i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            flush_idx    <= '0;
            out_valid    <= 1'b0;
            out_bit      <= 1'b0;
            out_last     <= 1'b0;
            frame_metric <= 6'd0;
            for (int i = 0; i < 4; i++) begin
                pm[i] <= (i == 0) ? 6'd0 : 6'd16;
                sr[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (accept) begin
                        for (int i = 0; i < 4; i++) begin
                            pm[i] <= pm_nxt[i];
                            sr[i] <= sr_nxt[i];
                        end
                        cnt <= cnt_nxt;
                        if (cnt_nxt == CNT_FULL) begin
                            out_valid <= 1'b1;
                            out_bit   <= sr_nxt[best][TB_DEPTH-1];
                        end
                        if (in_last) begin
                            state     <= FLUSH;
                            flush_idx <= FW'(flush_len - 1'b1);
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                FLUSH: begin
                    // Zero-terminated frame: the survivor of state 0 holds the tail window.
                    out_valid <= 1'b1;
                    out_bit   <= sr[0][flush_idx];
                    if (flush_idx == '0) begin
                        out_last     <= 1'b1;
                        frame_metric <= pm[0];
                        state        <= IDLE;
                        cnt          <= '0;
                        for (int i = 0; i < 4; i++) begin
                            pm[i] <= (i == 0) ? 6'd0 : 6'd16;
                            sr[i] <= '0;
                        end
                    end else begin
                        flush_idx <= flush_idx - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_viterbi_decoder.sv
// Scoreboard bench for conv_viterbi_decoder: known vectors, encoded random frames,
// backpressure through flush, mid-frame reset and a long noise frame.
module tb_conv_viterbi_decoder;

    localparam int TB_DEPTH = 16;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_sym   = 2'b00;
    logic       in_last  = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;
    logic [5:0] frame_metric;

    always #5 clk = ~clk;

    conv_viterbi_decoder #(
        .G1(3'b111),
        .G2(3'b101),
        .TB_DEPTH(TB_DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_sym(in_sym),
        .in_last(in_last),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_bit(out_bit),
        .out_last(out_last),
        .frame_metric(frame_metric)
    );

    int checks        = 0;
    int passed        = 0;
    int out_total     = 0;
    int frame_out_cnt = 0;

    bit         exp_bit_q    [$];
    bit         exp_care_q   [$];
    bit         exp_last_q   [$];
    int         exp_metric_q [$];
    bit         frame_bits   [$];
    logic [1:0] frame_syms   [$];
    logic [2:0] g1 = 3'b111;
    logic [2:0] g2 = 3'b101;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference encoder: shift register of the information bits, zero initial state.
    function automatic void encode_frame();
        bit u, u1, u2;
        frame_syms.delete();
        for (int k = 0; k < frame_bits.size(); k++) begin
            u  = frame_bits[k];
            u1 = (k >= 1) ? frame_bits[k-1] : 1'b0;
            u2 = (k >= 2) ? frame_bits[k-2] : 1'b0;
            frame_syms.push_back({(g1[2] & u) ^ (g1[1] & u1) ^ (g1[0] & u2),
                                  (g2[2] & u) ^ (g2[1] & u1) ^ (g2[0] & u2)});
        end
    endfunction

    function automatic void random_frame(input int n_info);
        frame_bits.delete();
        for (int k = 0; k < n_info; k++) frame_bits.push_back(1'($urandom));
        frame_bits.push_back(1'b0);
        frame_bits.push_back(1'b0);
        encode_frame();
    endfunction

    function automatic void spec_frame(input bit with_error);
        logic [5:0]  bv = 6'b101100;
        logic [11:0] sv = 12'b11_10_00_01_01_11;
        frame_bits.delete();
        frame_syms.delete();
        for (int k = 0; k < 6; k++) begin
            frame_bits.push_back(bv[5-k]);
            frame_syms.push_back(sv[11-2*k -: 2]);
        end
        if (with_error) frame_syms[2] = 2'b10;
    endfunction

    function automatic void push_frame(input bit care, input int metric);
        for (int k = 0; k < frame_bits.size(); k++) begin
            exp_bit_q.push_back(frame_bits[k]);
            exp_care_q.push_back(care);
            exp_last_q.push_back(k == frame_bits.size() - 1);
        end
        exp_metric_q.push_back(metric);
    endfunction

    // Entered and left at posedge+1. While in_ready is low, drives garbage (valid if hold).
    task automatic send_frame(input int n, input int stop, input bit hold);
        int i     = 0;
        int guard = 0;
        bit acc;
        while (i < stop) begin
            if (in_ready) begin
                in_valid = 1'b1;
                in_sym   = frame_syms[i];
                in_last  = (i == n - 1);
            end else begin
                in_valid = hold;
                in_sym   = 2'($urandom);
                in_last  = 1'($urandom);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            guard++;
            if (guard > stop + 300) begin
                check("send_timeout", i, stop);
                break;
            end
        end
        if (i == n) begin
            check("in_ready_in_flush", int'(in_ready), 0);
            check("run_outputs_before_last", frame_out_cnt, (n >= TB_DEPTH) ? n - TB_DEPTH : 0);
        end
        if (hold) begin
            in_valid = 1'b1;
            in_sym   = 2'($urandom);
            in_last  = 1'b1;
        end else begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_bit_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (exp_bit_q.size() != 0) begin
            check("drain_timeout", exp_bit_q.size(), 0);
            exp_bit_q.delete();
            exp_care_q.delete();
            exp_last_q.delete();
            exp_metric_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit care, input int metric);
        int base = out_total;
        int n    = frame_syms.size();
        push_frame(care, metric);
        send_frame(n, n, 1'b0);
        wait_drain();
        check("frame_out_count", out_total - base, n);
    endtask

    // Monitor: pops one expectation per out_valid pulse.
    initial begin
        bit eb, ec, el;
        int em;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid) begin
                out_total++;
                frame_out_cnt++;
                if (exp_bit_q.size() == 0) begin
                    check("unexpected_out_valid", int'(out_valid), 0);
                end else begin
                    eb = exp_bit_q.pop_front();
                    ec = exp_care_q.pop_front();
                    el = exp_last_q.pop_front();
                    if (ec) check("out_bit", int'(out_bit), int'(eb));
                    check("out_last", int'(out_last), int'(el));
                    if (el && exp_metric_q.size() != 0) begin
                        em = exp_metric_q.pop_front();
                        if (em >= 0) check("frame_metric", int'(frame_metric), em);
                    end
                end
                if (out_last) frame_out_cnt = 0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_bit", int'(out_bit), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_frame_metric", int'(frame_metric), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        spec_frame(1'b0);
        run_frame(1'b1, 0);
        spec_frame(1'b1);
        run_frame(1'b1, 1);

        // Abort a 40-symbol frame after its 10th symbol; nothing may come out.
        random_frame(38);
        send_frame(40, 10, 1'b0);
        reset_n = 1'b0;
        frame_out_cnt = 0;
        #1;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out_last", int'(out_last), 0);
        check("abort_frame_metric", int'(frame_metric), 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        base = out_total;
        repeat (40) @(posedge clk);
        #1;
        check("no_output_after_abort", out_total - base, 0);
        spec_frame(1'b0);
        run_frame(1'b1, 0);

        random_frame(38);
        run_frame(1'b1, 0);
        for (int f = 0; f < 4; f++) begin
            random_frame(int'($urandom_range(1, 50)));
            run_frame(1'b1, 0);
        end

        // Backpressure: in_valid stays high with garbage through flush.
        base = out_total;
        random_frame(18);
        push_frame(1'b1, 0);
        send_frame(20, 20, 1'b1);
        random_frame(10);
        push_frame(1'b1, 0);
        send_frame(12, 12, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_drain();
        check("bp_out_count", out_total - base, 32);

        // Noise frame of all-11 symbols; only framing is predictable.
        frame_bits.delete();
        frame_syms.delete();
        for (int k = 0; k < 200; k++) begin
            frame_bits.push_back(1'b0);
            frame_syms.push_back(2'b11);
        end
        run_frame(1'b0, -1);

        check("metric_queue_empty", exp_metric_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/conv_viterbi_decoder.md
CONV_VITERBI_DECODER -- requirements
Module: conv_viterbi_decoder

Interface
REQ-001 The block SHALL have parameter G1, default 3'b111, generator for code bit 1; bit 2 taps u[n], bit 1 taps u[n-1], bit 0 taps u[n-2].
REQ-002 The block SHALL have parameter G2, default 3'b101, generator for code bit 0, with the same tap mapping.
REQ-003 The block SHALL have parameter TB_DEPTH, default 16, survivor depth in symbols, legal range 4..32.
REQ-004 The block SHALL have ports as follows; reset is reset_n, asynchronous, active-low, and the clock is clk:
  clk  in  1  clock, rising edge
  reset_n  in  1  asynchronous active-low reset
  in_valid  in  1  in_sym valid this cycle
  in_sym  in  2  hard-decision symbol, [1] = G1 bit, [0] = G2 bit
  in_last  in  1  qualifies the final symbol of the frame (tail included)
  in_ready  out  1  decoder accepts a symbol when in_valid & in_ready
  out_valid  out  1  out_bit valid, single-cycle pulse per bit
  out_bit  out  1  decoded information bit, oldest first
  out_last  out  1  marks the final decoded bit of the frame
  frame_metric  out  6  best path metric of the last frame, held until the next frame ends

Function
REQ-005 The FSM SHALL have three states: IDLE, RUN and FLUSH. The transitions are:
  - IDLE to RUN on the first accepted symbol.
  - RUN to FLUSH on an accepted symbol with in_last=1, including a symbol accepted in IDLE.
  - FLUSH to IDLE after out_last is emitted.
REQ-006 in_ready SHALL be 1 in IDLE and RUN and 0 in FLUSH; in_valid during FLUSH SHALL be ignored.
REQ-007 The trellis SHALL have 4 states, with s = {u[n-1], u[n-2]} and next state ns = {u, s[1]}; the predecessors of ns are {ns[0], 0} and {ns[0], 1}, and the input bit is ns[1].
REQ-008 The expected symbol SHALL be {^(G1 & {u, s}), ^(G2 & {u, s})}, and the branch metric SHALL be popcount(in_sym ^ expected), in the range 0..2.
REQ-009 Add-compare-select SHALL keep the smaller candidate metric; on a tie, the predecessor with s[0]=0 SHALL be selected.
REQ-010 Path metrics SHALL be 6-bit unsigned and SHALL saturate at 63. When all four new metrics are >= 32, 32 SHALL be subtracted from each in the same cycle.
REQ-011 At frame start (IDLE), the metrics SHALL be PM[0]=0 and PM[1..3]=16, and all survivor registers SHALL be 0.
REQ-012 The survivor memory SHALL use register exchange: SR[ns] = {SR[pred][TB_DEPTH-2:0], u}, so the newest bit is at the LSB.
REQ-013 A symbol counter SHALL count accepted symbols in the frame and saturate at TB_DEPTH.
REQ-014 In RUN, for each accepted symbol that takes the count to >= TB_DEPTH, one bit SHALL be emitted with out_valid=1 one cycle after acceptance. That bit is SR[best][TB_DEPTH-1], where best is the minimum-metric state after the update; ties go to the lowest index.
REQ-015 In FLUSH, bits SHALL come from SR[0], because the frame is zero-terminated. M = min(N, TB_DEPTH-1) bits SHALL be emitted, where N is the frame symbol count. They go out one per cycle on consecutive cycles, at indices M-1 down to 0, starting the cycle after the in_last symbol is accepted.
REQ-016 out_last SHALL be 1 together with the final FLUSH bit. On that same edge, frame_metric SHALL load PM[0].
REQ-017 The total number of decoded bits per frame SHALL equal N, including the K-1=2 tail bits; dropping the tail bits is the consumer's job.
REQ-018 Any RUN-emitted output and the first FLUSH bit SHALL NOT both occur in the same cycle. The last RUN output for the in_last symbol SHALL precede the FLUSH bits by one cycle.

Reset
REQ-019 While reset_n=0, the block SHALL be in IDLE, out_valid=0, out_bit=0, out_last=0, frame_metric=0, in_ready=1, the metrics at their frame-start values, and the survivors and counter at 0.
REQ-020 Reset assertion mid-frame SHALL immediately abort the frame with no further outputs. After release, decoding SHALL begin as a fresh frame.

Verification
REQ-021 Error-free short frame: symbols 11,10,00,01,01,11 (in_last on the 6th) SHALL produce out_bit 1,0,1,1,0,0 on 6 consecutive FLUSH cycles, with out_last on the 6th and frame_metric=0.
REQ-022 One error: the same frame with the 3rd symbol changed to 10 SHALL produce out_bit 1,0,1,1,0,0, with frame_metric=1.
REQ-023 Long frame: 38 random information bits plus 2 zero tail bits, error-free, give 40 symbols. The bench SHALL see 25 RUN outputs and then 15 FLUSH outputs, matching the input bits in order, with frame_metric=0.
REQ-024 Backpressure: in_valid held at 1 through FLUSH SHALL cause no symbols to be accepted while in_ready=0. The next frame SHALL decode correctly from the first symbol after IDLE.
REQ-025 Reset mid-frame: asserting reset_n=0 after the 10th symbol of a 40-symbol frame SHALL produce no further out_valid. After release, a new REQ-021 frame SHALL decode to 1,0,1,1,0,0.
REQ-026 Metric normalization: a 200-symbol all-11 noise frame SHALL keep all metrics <= 63, complete with exactly 200 out_valid pulses, and assert out_last once.
